// File: rtl/inst_fetch_bridge_pkg.sv
// Shared constants and FSM encoding for the instruction fetch bridge.
package inst_fetch_bridge_pkg;

  localparam logic RST_ENABLE      = 1'b0;
  localparam int   INST_BUS_W      = 32;
  localparam int   INST_ADDR_BUS_W = 32;
  localparam int   LINE_WORDS_DEF  = 4;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_FILL = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// Core fetch port plus req/ack instruction-memory port, seen from the bridge (slave) or its environment (master).
interface inst_fetch_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr_i;
  logic [DATA_W-1:0] rom_data_o;
  logic              stall_o;
  logic              flush_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  rom_ce, rom_addr_i, flush_i, mem_ack_i, mem_data_i,
    output rom_data_o, stall_o, mem_req_o, mem_addr_o
  );

  modport master (
    output rom_ce, rom_addr_i, flush_i, mem_ack_i, mem_data_i,
    input  rom_data_o, stall_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/inst_fetch_bridge_line_buf.sv
// One-line instruction buffer: single write port, combinational read port.
module inst_fetch_bridge_line_buf #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [OFF_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [OFF_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [LINE_WORDS-1:0][DATA_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // No reset: contents are only ever consumed behind the line-valid bit.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch_bridge.sv
// Instruction-side bridge: single-line buffer in front of a req/ack memory, stalling the core on a miss.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W     = INST_ADDR_BUS_W,
  parameter int DATA_W     = INST_BUS_W,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_bridge_if.slave  bus
);

  localparam int              OFF_W     = $clog2(LINE_WORDS);
  localparam int              TAG_W     = ADDR_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  fetch_state_e     state_q, state_d;
  logic             line_valid_q, line_valid_d;
  logic             flush_pend_q, flush_pend_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
  logic [OFF_W-1:0] word_cnt_q, word_cnt_d;

  logic [TAG_W-1:0]  req_tag;
  logic [OFF_W-1:0]  req_word;
  logic              hit;
  logic              line_we;
  logic [DATA_W-1:0] rdata;
  logic              unused_addr_bits;

  assign req_tag          = bus.rom_addr_i[ADDR_W-1:OFF_W+2];
  assign req_word         = bus.rom_addr_i[OFF_W+1:2];
  assign unused_addr_bits = ^bus.rom_addr_i[1:0];

  inst_fetch_bridge_line_buf #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk   (clk),
    .we    (line_we),
    .waddr (word_cnt_q),
    .wdata (bus.mem_data_i),
    .raddr (req_word),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q      <= FETCH_IDLE;
      line_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      tag_q        <= '0;
      fill_tag_q   <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      flush_pend_q <= flush_pend_d;
      tag_q        <= tag_d;
      fill_tag_q   <= fill_tag_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    flush_pend_d = flush_pend_q;
    tag_d        = tag_q;
    fill_tag_d   = fill_tag_q;
    word_cnt_d   = word_cnt_q;
    unique case (state_q)
      FETCH_IDLE: begin
        if (bus.flush_i) line_valid_d = 1'b0;
        // Starting a fill discards the old line immediately.
        if (bus.rom_ce && !hit) begin
          state_d      = FETCH_FILL;
          fill_tag_d   = req_tag;
          word_cnt_d   = '0;
          line_valid_d = 1'b0;
          flush_pend_d = 1'b0;
        end
      end
      FETCH_FILL: begin
        if (bus.flush_i) flush_pend_d = 1'b1;
        if (bus.mem_ack_i) begin
          word_cnt_d = word_cnt_q + OFF_W'(1);
          if (word_cnt_q == LAST_WORD) begin
            state_d      = FETCH_IDLE;
            tag_d        = fill_tag_q;
            // A flush seen at any point of the fill (including this cycle) leaves the line invalid.
            line_valid_d = !(flush_pend_q || bus.flush_i);
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_comb begin
    hit            = bus.rom_ce && line_valid_q && (req_tag == tag_q) && (state_q == FETCH_IDLE);
    bus.rom_data_o = hit ? rdata : '0;
    bus.stall_o    = (rst != RST_ENABLE) && bus.rom_ce && !hit;
    bus.mem_req_o  = (state_q == FETCH_FILL);
    bus.mem_addr_o = bus.mem_req_o ? {fill_tag_q, word_cnt_q, 2'b00} : '0;
    line_we        = bus.mem_req_o && bus.mem_ack_i;
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench: fetches drive a scoreboard of expected words, a small memory model answers fills.
module tb_inst_fetch_bridge;
  import inst_fetch_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_bridge_if bus ();

  inst_fetch_bridge dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          ncmp = 0;
  int          nerr = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a < 32'h10) return (32'(a[3:2]) + 32'd1) * 32'h11;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Fetch one address; serve fills with `wt` wait cycles per word. flush_at/rst_at name the ack
  // count at which a flush pulse / reset is injected (-1 = never).
  task automatic fetch(input logic [31:0] a, input int wt, input int exp_stall, input int exp_acks,
                       input int flush_at, input int rst_at);
    int          stalls = 0;
    int          acks   = 0;
    int          age    = 0;
    logic [1:0]  wi     = 2'd0;
    logic [31:0] ea;
    logic        done   = 1'b0;
    @(negedge clk);
    bus.rom_ce     = 1'b1;
    bus.rom_addr_i = a;
    exp_q.push_back(model({a[31:2], 2'b00}));
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (!bus.stall_o) begin
        check("rom_data", bus.rom_data_o, exp_q.pop_front());
        check("stall_cycles", stalls, exp_stall);
        check("acks", acks, exp_acks);
        done = 1'b1;
      end else begin
        stalls++;
        if (bus.mem_req_o) begin
          ea = {a[31:4], wi, 2'b00};
          check("mem_addr", bus.mem_addr_o, ea);
          if (age == wt) begin
            bus.mem_ack_i  = 1'b1;
            bus.mem_data_i = model(ea);
            acks++;
            wi++;
            age = 0;
            if (acks == flush_at) bus.flush_i = 1'b1;
          end else begin
            age++;
            bus.mem_data_i = 32'hDEAD_BEEF;
          end
        end
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        bus.flush_i   = 1'b0;
        if (acks == rst_at) begin
          rst = 1'b0;
          #1;
          check("rst_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
          check("rst_stall", {31'b0, bus.stall_o}, 32'd0);
          check("rst_mem_addr", bus.mem_addr_o, 32'd0);
          check("rst_rom_data", bus.rom_data_o, 32'd0);
          void'(exp_q.pop_front());
          bus.rom_ce = 1'b0;
          @(negedge clk);
          rst  = 1'b1;
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      check("fetch_done", {31'b0, done}, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rom_ce     = 1'b1;
    bus.rom_addr_i = 32'h8;
    bus.flush_i    = 1'b0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    #12;
    check("reset_stall", {31'b0, bus.stall_o}, 32'd0);
    check("reset_rom_data", bus.rom_data_o, 32'd0);
    check("reset_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
    check("reset_mem_addr", bus.mem_addr_o, 32'd0);
    @(negedge clk);
    bus.rom_ce = 1'b0;
    rst        = 1'b1;

    // Cold miss then same-cycle hit.
    fetch(32'h0, 0, 5, 4, -1, -1);
    fetch(32'h8, 0, 0, 0, -1, -1);

    // Wait states: 3 idle cycles before each ack.
    fetch(32'h20, 3, 17, 4, -1, -1);
    fetch(32'h24, 0, 0, 0, -1, -1);
    fetch(32'h28, 0, 0, 0, -1, -1);
    fetch(32'h2C, 0, 0, 0, -1, -1);

    // Line switches.
    fetch(32'h10, 0, 5, 4, -1, -1);
    fetch(32'h14, 0, 0, 0, -1, -1);
    fetch(32'h4, 0, 5, 4, -1, -1);

    // Flush during fill: line invalid at completion, immediate refill.
    fetch(32'h30, 0, 10, 8, 2, -1);
    // Flush while idle on a valid line.
    @(negedge clk);
    bus.rom_ce  = 1'b0;
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    fetch(32'h30, 0, 5, 4, -1, -1);
    fetch(32'h3C, 0, 0, 0, -1, -1);

    // Idle with spurious acks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.rom_ce     = 1'b0;
      bus.rom_addr_i = 32'h100;
      bus.mem_ack_i  = 1'b1;
      bus.mem_data_i = 32'h0BAD_0BAD;
      #1;
      check("idle_rom_data", bus.rom_data_o, 32'd0);
      check("idle_stall", {31'b0, bus.stall_o}, 32'd0);
      check("idle_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
    end
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    fetch(32'h38, 0, 0, 0, -1, -1);

    // Reset after the 2nd ack, then a clean refill from word 0.
    fetch(32'h0, 0, 0, 0, -1, 2);
    fetch(32'h0, 0, 5, 4, -1, -1);
    fetch(32'hC, 0, 0, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
